// File: rtl/sn74ls197.sv
// 74LS197-style presettable 4-bit counter: a divide-by-2 section (QA) and a
// divide-by-8 section (QB-QD), each advanced by a sampled falling edge of its count input.
module sn74ls197 (
    input  logic       clk,
    input  logic       clr,
    input  logic       clk1,
    input  logic       clk2,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] q_q, q_d;
    logic       clk1_q, clk2_q;
    logic       fall1, fall2;

    // Divide-by-8 section step, wrapping 111 -> 000.
    function automatic logic [2:0] inc_mod8(input logic [2:0] v);
        return v + 3'd1;
    endfunction

    // An X/Z on either operand makes the edge term unknown, and an unknown if-condition never counts.
    always_comb begin
        fall1 = clk1_q & ~clk1;
        fall2 = clk2_q & ~clk2;
        q_d   = q_q;
        if (load == 1'b0) begin
            q_d = d;
        end else begin
            if (fall1) q_d[0]   = ~q_q[0];
            if (fall2) q_d[3:1] = inc_mod8(q_q[3:1]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q    <= 4'b0000;
            clk1_q <= 1'b0;
            clk2_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            clk1_q <= clk1;
            clk2_q <= clk2;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_sn74ls197.sv
// Self-checking bench for sn74ls197: directed scenarios plus randomized traffic
// compared against a cycle-level arithmetic model of the counter.
module tb_sn74ls197;

    logic       clk = 1'b0;
    logic       clr, clk1, clk2_drv, load, cascade;
    logic [3:0] d, q;
    logic       clk2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: counter value and last sampled level of each count input.
    logic [3:0] m;
    logic       p1, p2;

    assign clk2 = cascade ? q[0] : clk2_drv;

    sn74ls197 dut (
        .clk  (clk),
        .clr  (clr),
        .clk1 (clk1),
        .clk2 (clk2),
        .load (load),
        .d    (d),
        .q    (q)
    );

    always #5 clk = ~clk;

    // Advance the model by one clk edge from the current inputs, then let the DUT take that edge.
    task automatic step();
        logic c2;
        int   lo, hi;
        c2 = cascade ? m[0] : clk2_drv;
        if (clr) begin
            m  = 4'd0;
            p1 = 1'b0;
            p2 = 1'b0;
        end else begin
            if (load === 1'b0) begin
                m = d;
            end else begin
                lo = int'(m) % 2;
                hi = int'(m) / 2;
                if (p1 == 1'b1 && clk1 == 1'b0) lo = 1 - lo;
                if (p2 == 1'b1 && c2 == 1'b0)   hi = (hi + 1) % 8;
                m = 4'(hi * 2 + lo);
            end
            p1 = clk1;
            p2 = c2;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_clear();
        m  = 4'd0;
        p1 = 1'b0;
        p2 = 1'b0;
    endtask

    // Mid-cycle clear pulse that never spans a clk edge.
    task automatic pulse_clr();
        #1 clr = 1'b1;
        model_clear();
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; clk1 = 1'b0; clk2_drv = 1'b0; load = 1'b1; d = 4'd0; cascade = 1'b0;
        #1 clr = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_initial: q=%b expected 0000", q);
        end
        @(negedge clk);
        clr = 1'b0; load = 1'b0; d = 4'b1010;
        step();
        load = 1'b1;
        step();
        n_checks++;
        if (q !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_preload: q=%b expected 1010", q);
        end
        #1 clr = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: q=%b expected 0000 before any clk edge", q);
        end
        #1 clr = 1'b0;
        @(negedge clk);
        steps(2);
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: q=%b expected 0000", q);
        end
        // A pending clk1 fall coinciding with clear must be discarded.
        clk1 = 1'b1;
        steps(2);
        clk1 = 1'b0;
        pulse_clr();
        steps(2);
        n_checks++;
        if (q !== 4'b0000 || q !== m) begin
            n_fail++;
            $display("FAIL reset_discard_edge: q=%b expected 0000", q);
        end
    endtask

    task automatic test_load();
        load = 1'b0; d = 4'b0101;
        step();
        n_checks++;
        if (q !== 4'b0101) begin
            n_fail++;
            $display("FAIL load_basic: q=%b expected 0101", q);
        end
        clk1 = 1'b1; steps(2);
        clk1 = 1'b0; steps(2);
        clk1 = 1'b1; steps(2);
        clk1 = 1'b0; steps(2);
        n_checks++;
        if (q !== 4'b0101) begin
            n_fail++;
            $display("FAIL load_hold: q=%b expected 0101 while load low", q);
        end
        load = 1'b1;
        steps(2);
    endtask

    task automatic test_div16();
        logic [3:0] exp;
        cascade = 1'b1; clk1 = 1'b0; load = 1'b0; d = 4'b0101;
        step();
        load = 1'b1;
        steps(2);
        for (int i = 0; i < 16; i++) begin
            clk1 = 1'b1; steps(10);
            clk1 = 1'b0; steps(10);
            exp = 4'(5 + i + 1);
            n_checks++;
            if (q !== exp || q !== m) begin
                n_fail++;
                $display("FAIL div16_pulse%0d: q=%b expected %b (model %b)", i, q, exp, m);
            end
        end
        cascade = 1'b0; clk2_drv = q[0];
        steps(2);
    endtask

    task automatic test_independent();
        clk1 = 1'b0; clk2_drv = 1'b0;
        pulse_clr();
        steps(2);
        for (int i = 0; i < 3; i++) begin
            clk1 = 1'b1; steps(2);
            clk1 = 1'b0; steps(2);
        end
        n_checks++;
        if (q !== 4'b0001) begin
            n_fail++;
            $display("FAIL indep_qa: q=%b expected 0001", q);
        end
        for (int i = 0; i < 9; i++) begin
            clk2_drv = 1'b1; steps(2);
            clk2_drv = 1'b0; steps(2);
        end
        n_checks++;
        if (q !== 4'b0011) begin
            n_fail++;
            $display("FAIL indep_wrap: q=%b expected 0011", q);
        end
    endtask

    task automatic test_simultaneous();
        pulse_clr();
        steps(2);
        clk1 = 1'b1; steps(2);
        clk1 = 1'b0; steps(2);
        clk1 = 1'b1; clk2_drv = 1'b1; steps(2);
        n_checks++;
        if (q !== 4'b0001) begin
            n_fail++;
            $display("FAIL simul_setup: q=%b expected 0001", q);
        end
        clk1 = 1'b0; clk2_drv = 1'b0;
        step();
        n_checks++;
        if (q !== 4'b0010) begin
            n_fail++;
            $display("FAIL simul_edges: q=%b expected 0010", q);
        end
        step();
    endtask

    task automatic test_priority();
        clk1 = 1'b1; steps(2);
        load = 1'b0; d = 4'b1100; clk1 = 1'b0;
        step();
        n_checks++;
        if (q !== 4'b1100) begin
            n_fail++;
            $display("FAIL prio_load_over_edge: q=%b expected 1100", q);
        end
        #1 clr = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL prio_clr_over_load: q=%b expected 0000", q);
        end
        @(negedge clk);
        step();
        n_checks++;
        if (q !== 4'b0000) begin
            n_fail++;
            $display("FAIL prio_clr_held: q=%b expected 0000", q);
        end
        clr = 1'b0; load = 1'b1;
        steps(2);
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 8; blk++) begin
            cascade = 1'($urandom_range(0, 1));
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 2) == 0) clk1 = ~clk1;
                if ($urandom_range(0, 2) == 0) clk2_drv = ~clk2_drv;
                load = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
                d    = 4'($urandom);
                if ($urandom_range(0, 39) == 0) pulse_clr();
                step();
                n_checks++;
                if (q !== m) begin
                    n_fail++;
                    $display("FAIL random_b%0d_c%0d: q=%b expected %b", blk, i, q, m);
                end
            end
        end
        cascade = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_div16();
        test_independent();
        test_simultaneous();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
